lc3_decode_ctrl: RTL and testbench
==================================

Name: lc3_decode_ctrl

Overview:
- Control-side partner of the LC3 fetch unit.
- Waits for the instruction word that memory returns at the current PC and latches it into an instruction register (IR).
- Splits the IR into fields and presents the opcode, the 9-bit offset and the branch condition bits to fetch.
- After execute signals completion, pulses fetch_start so fetch advances the PC, then the cycle repeats.

Parameters:
- MEM_LATENCY, 2, cycles from a PC change until mem_dout is valid (block RAM read latency); legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- run  input  1  level; allows the first instruction to be fetched after reset
- mem_dout  input  16  instruction word from memory at the fetch pc
- exec_done  input  1  one-cycle pulse from execute: the current instruction has retired
- fetch_start  output  1  one-cycle pulse to fetch: advance or redirect the PC
- opCode_out  output  4  IR[15:12], goes to fetch opCode_in and to execute
- offset_out  output  9  IR[8:0], goes to fetch offset_in
- br_nzp  output  3  IR[11:9] when the opcode is BR (0000), else 3'b000
- dr  output  3  IR[11:9], destination register / store source
- sr1  output  3  IR[8:6], source register 1 / base register
- sr2  output  3  IR[2:0], source register 2
- imm5  output  5  IR[4:0]
- imm_sel  output  1  IR[5]
- ir  output  16  latched instruction register
- decode_valid  output  1  one-cycle pulse: all decoded fields are valid for execute
- illegal_op  output  1  one-cycle pulse: reserved opcode 1101 was decoded
- halted  output  1  level; only present when DECODE_TRAP_HALT_EN is defined

Behaviour:
- Reset (rst_n=0, any state, takes effect immediately): state=IDLE, ir=16'h0000, latency counter=0; every output is 0.
- All decoded outputs are combinational from ir only. They are stable from LATCH+1 until the next LATCH.

State machine:
- IDLE: stays here while run=0. When run=1, load cnt=MEM_LATENCY-1 and go to MEM_WAIT.
- MEM_WAIT: decrement cnt each cycle. When cnt==0, go to LATCH. Total dwell is exactly MEM_LATENCY cycles.
- LATCH: ir<=mem_dout. Next state is ISSUE.
- ISSUE: decode_valid=1 for this one cycle.
  - Opcode 1101: illegal_op=1 in the same cycle; skip execute and go to FETCH.
  - Any other opcode: go to EXEC_WAIT.
- EXEC_WAIT: hold until exec_done=1, then go to FETCH.
  - exec_done seen in any other state is ignored.
- FETCH: fetch_start=1 for exactly one cycle. Reload cnt=MEM_LATENCY-1 and go to MEM_WAIT.
  - run is sampled only in IDLE. Dropping run mid-instruction does not stop the loop.

Timing and handshake:
- Minimum instruction period is MEM_LATENCY+4 cycles, reached when exec_done arrives on the first EXEC_WAIT cycle.
- fetch_start is never asserted in two consecutive cycles.
- fetch_start is never asserted while the FSM is in IDLE or MEM_WAIT.
- The fetch unit sees opCode_out/offset_out/br_nzp stable during the fetch_start cycle. This lets it compute a BR/JMP/JSR target in that same cycle.

Boundary cases:
- exec_done asserted in the same cycle as ISSUE is ignored; execute must pulse it after decode_valid.
- Reset asserted while in FETCH: the fetch_start pulse is suppressed immediately (asynchronous reset).
- ir=16'h0000 (BR with nzp=000) is a legal instruction; it decodes as a never-taken branch.

Optional Feature:
DECODE_TRAP_HALT_EN
- Defined:
  - The halted port exists.
  - In ISSUE, if ir==16'hF025 (TRAP x25, HALT), go to HALT.
  - HALT: halted=1; no further fetch_start; exec_done is ignored.
  - Only reset leaves HALT; after reset, halted=0.
- Not defined:
  - There is no halted port.
  - 16'hF025 is treated as an ordinary TRAP: EXEC_WAIT, then FETCH.

Test Plan:
- Reset with run=0 held 5 cycles, then rst_n=1 -> all outputs 0, no fetch_start for 20 cycles.
- run=1, mem_dout=16'h2205 (LD R1,#5), MEM_LATENCY=2:
  - decode_valid at cycle 4 after run, with opCode_out=4'b0010, dr=3'd1, offset_out=9'h005, br_nzp=3'b000.
  - exec_done pulsed 2 cycles later -> fetch_start exactly 1 cycle, on the following cycle.
- mem_dout=16'h0E03 (BRnzp #3) -> br_nzp=3'b111, offset_out=9'h003; fetch_start only after exec_done.
- mem_dout=16'hD000 -> illegal_op and decode_valid in the same cycle, fetch_start on the next cycle, no exec_done needed.
- rst_n pulled low during EXEC_WAIT -> ir=0 and outputs 0 immediately; after release with run=1, MEM_WAIT restarts with a full MEM_LATENCY count.
- With DECODE_TRAP_HALT_EN defined, mem_dout=16'hF025 -> halted=1 from the cycle after ISSUE, no fetch_start for 50 cycles even with exec_done pulsed.

Source files
------------

// File: rtl/lc3_decode_ctrl.sv
// LC3 decode/control sequencer: waits out the memory read, latches IR, decodes
// fields, hands off to execute and pulses fetch. Optional macro: DECODE_TRAP_HALT_EN.
module lc3_decode_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] mem_dout,
    input  logic        exec_done,
    output logic        fetch_start,
    output logic [3:0]  opCode_out,
    output logic [8:0]  offset_out,
    output logic [2:0]  br_nzp,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [4:0]  imm5,
    output logic        imm_sel,
    output logic [15:0] ir,
    output logic        decode_valid,
    output logic        illegal_op,
    output logic [2:0]  fsm_state
`ifdef DECODE_TRAP_HALT_EN
    ,
    output logic        halted
`endif
);

    // Handshake: fetch_start, decode_valid and illegal_op are single-cycle
    // pulses; exec_done is only honoured while waiting in ST_EXEC_WAIT.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEM_WAIT  = 3'd1,
        ST_LATCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_EXEC_WAIT = 3'd4,
        ST_FETCH     = 3'd5
`ifdef DECODE_TRAP_HALT_EN
        ,
        ST_HALT      = 3'd6
`endif
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       ir_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (ir_load) begin
                ir <= mem_dout;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ir_load      = 1'b0;
        fetch_start  = 1'b0;
        decode_valid = 1'b0;
        illegal_op   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    cnt_next   = CNT_LOAD;
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = ST_LATCH;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            ST_LATCH: begin
                ir_load    = 1'b1;
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                decode_valid = 1'b1;
                if (ir[15:12] == 4'b1101) begin
                    illegal_op = 1'b1;
                    state_next = ST_FETCH;
`ifdef DECODE_TRAP_HALT_EN
                end else if (ir == 16'hF025) begin
                    state_next = ST_HALT;
`endif
                end else begin
                    state_next = ST_EXEC_WAIT;
                end
            end
            ST_EXEC_WAIT: begin
                if (exec_done) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_start = 1'b1;
                cnt_next    = CNT_LOAD;
                state_next  = ST_MEM_WAIT;
            end
`ifdef DECODE_TRAP_HALT_EN
            ST_HALT: begin
                state_next = ST_HALT;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Decoded fields depend on ir alone, so they hold steady through FETCH.
    assign opCode_out = ir[15:12];
    assign offset_out = ir[8:0];
    assign br_nzp     = (ir[15:12] == 4'b0000) ? ir[11:9] : 3'b000;
    assign dr         = ir[11:9];
    assign sr1        = ir[8:6];
    assign sr2        = ir[2:0];
    assign imm5       = ir[4:0];
    assign imm_sel    = ir[5];
    assign fsm_state  = state;
`ifdef DECODE_TRAP_HALT_EN
    assign halted     = (state == ST_HALT);
`endif

endmodule

// File: tb/tb_lc3_decode_ctrl.sv
// Scoreboard bench for lc3_decode_ctrl: random instruction stream, decode and
// fetch_start timing checked against a cycle-level model of the control loop.
module tb_lc3_decode_ctrl;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n, run, exec_done;
    logic [15:0] mem_dout;
    logic        fetch_start, decode_valid, illegal_op, imm_sel;
    logic [3:0]  opCode_out;
    logic [8:0]  offset_out;
    logic [2:0]  br_nzp, dr, sr1, sr2, fsm_state;
    logic [4:0]  imm5;
    logic [15:0] ir;
`ifdef DECODE_TRAP_HALT_EN
    logic        halted;
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    lc3_decode_ctrl #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_dout(mem_dout),
        .exec_done(exec_done), .fetch_start(fetch_start),
        .opCode_out(opCode_out), .offset_out(offset_out), .br_nzp(br_nzp),
        .dr(dr), .sr1(sr1), .sr2(sr2), .imm5(imm5), .imm_sel(imm_sel),
        .ir(ir), .decode_valid(decode_valid), .illegal_op(illegal_op),
        .fsm_state(fsm_state)
`ifdef DECODE_TRAP_HALT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    int          exp_fetch_q[$];
    int          last_start_cyc = 0;
    int          g_cyc = -10;
    int          spur_cyc = -10;
    bit          hold_exec = 1'b0;
    bit          exp_halted = 1'b0;
    bit          prev_fs = 1'b0;
    logic [15:0] last_w = 16'h0000;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference decode computed from the instruction word by field arithmetic.
    function automatic int f_bits(input int w, input int lo, input int width);
        return (w >> lo) % (1 << width);
    endfunction

    // Monitor: pops expected words on decode_valid, schedules execute's
    // response, and checks fetch_start against the expected cycle queue.
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef DECODE_TRAP_HALT_EN
            chk("halted", halted, exp_halted);
`endif
            if (decode_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected decode_valid");
                end else begin
                    int w, op, d;
                    bit is_halt;
                    w = exp_q.pop_front();
                    last_w = w[15:0];
                    op = f_bits(w, 12, 4);
                    is_halt = HALT_EN && (w == 16'hF025);
                    chk("ir", ir, w);
                    chk("opcode", opCode_out, op);
                    chk("offset", offset_out, f_bits(w, 0, 9));
                    chk("br_nzp", br_nzp, (op == 0) ? f_bits(w, 9, 3) : 0);
                    chk("dr", dr, f_bits(w, 9, 3));
                    chk("sr1", sr1, f_bits(w, 6, 3));
                    chk("sr2", sr2, f_bits(w, 0, 3));
                    chk("imm5", imm5, f_bits(w, 0, 5));
                    chk("imm_sel", imm_sel, f_bits(w, 5, 1));
                    chk("illegal_op", illegal_op, (op == 13) ? 1 : 0);
                    chk("issue_latency", cyc - last_start_cyc, L + 2);
                    if (op == 13) begin
                        exp_fetch_q.push_back(cyc + 1);
                    end else if (!hold_exec) begin
                        d = $urandom_range(0, 3);
                        g_cyc = cyc + 1 + d;
                        spur_cyc = ($urandom_range(0, 1) == 1) ? cyc : -10;
                        if (!is_halt) exp_fetch_q.push_back(g_cyc + 1);
                    end
                    if (is_halt) exp_halted = 1'b1;
                end
            end else if (illegal_op) begin
                fail("illegal_op without decode_valid");
            end
            if (fetch_start) begin
                if (prev_fs) fail("fetch_start in consecutive cycles");
                if (exp_fetch_q.size() == 0) begin
                    fail("unexpected fetch_start");
                end else begin
                    chk("fetch_cycle", cyc, exp_fetch_q.pop_front());
                end
                chk("fetch_opcode_stable", opCode_out, f_bits(last_w, 12, 4));
                chk("fetch_offset_stable", offset_out, f_bits(last_w, 0, 9));
                last_start_cyc = cyc;
            end
            prev_fs = fetch_start;
            exec_done = (cyc == g_cyc) || (cyc == spur_cyc);
        end else begin
            prev_fs = 1'b0;
            exec_done = 1'b0;
        end
    end

    task automatic wait_fetch();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!fetch_start && t < 60);
        if (!fetch_start) fail("fetch_start timeout");
    endtask

    task automatic wait_decode();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!decode_valid && t < 60);
        if (!decode_valid) fail("decode_valid timeout");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_fetch_start"}, fetch_start, 0);
        chk({tag, "_decode_valid"}, decode_valid, 0);
        chk({tag, "_illegal_op"}, illegal_op, 0);
        chk({tag, "_opcode"}, opCode_out, 0);
        chk({tag, "_offset"}, offset_out, 0);
        chk({tag, "_br_nzp"}, br_nzp, 0);
        chk({tag, "_state"}, fsm_state, 0);
    endtask

    logic [15:0] words[$];

    initial begin
        logic [15:0] w;
        rst_n = 1'b0;
        run = 1'b0;
        exec_done = 1'b0;
        mem_dout = 16'h2205;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("idle");

        words = '{16'h2205, 16'h0E03, 16'hD000, 16'h0000};
        if (!HALT_EN) words.push_back(16'hF025);
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom_range(0, 16'hFFFF));
            if (HALT_EN && w == 16'hF025) w = 16'hF026;
            words.push_back(w);
        end

        foreach (words[i]) begin
            mem_dout = words[i];
            exp_q.push_back(words[i]);
            if (i == 0) begin
                run = 1'b1;
                last_start_cyc = cyc;
            end
            wait_fetch();
        end

        // Reset while parked in EXEC_WAIT, then restart from IDLE.
        mem_dout = 16'h1042;
        exp_q.push_back(16'h1042);
        hold_exec = 1'b1;
        wait_decode();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        hold_exec = 1'b0;
        mem_dout = 16'h5A3F;
        exp_q.push_back(16'h5A3F);
        rst_n = 1'b1;
        last_start_cyc = cyc;
        wait_fetch();

`ifdef DECODE_TRAP_HALT_EN
        mem_dout = 16'hF025;
        exp_q.push_back(16'hF025);
        wait_decode();
        repeat (50) @(negedge clk);
        chk("halted_after_50", halted, 1);
`endif

        @(negedge clk);
        rst_n = 1'b0;
        exp_halted = 1'b0;
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("fetch_q_drained", exp_fetch_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
